// File: rtl/fpu_pkg.sv
// fpu_pkg: constants and types shared by the single-precision FPU pipelines.
package fpu_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int MANT_W  = FRAC_W + 1;
  localparam int C1_W    = 36;
  localparam int PROD_W  = 2 * MANT_W;
  localparam int EXP_X_W = 10;

  localparam int BIAS = 127;

  localparam logic [EXP_W-1:0]   EXP_MAX   = 8'hFF;
  localparam logic [FRAC_W-1:0]  QNAN_FRAC = 23'h400000;
  localparam logic [EXP_X_W-1:0] BIAS_X    = EXP_X_W'(BIAS);

  // Status flags carried alongside a packed result.
  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
    logic error;
  } flags_t;

endpackage

// File: rtl/fmul_round_rne.sv
// fmul_round_rne: normalizes a 48-bit mantissa product and rounds it to
// nearest-even. Purely combinational so it can sit inside any pipeline stage.
module fmul_round_rne
  import fpu_pkg::*;
(
  input  logic [PROD_W-1:0] p,
  output logic [FRAC_W-1:0] frac,
  output logic [1:0]        inc,
  output logic              inexact
);

  logic [FRAC_W-1:0] m;
  logic              g;
  logic              s;
  logic              norm_inc;
  logic              up;
  logic [FRAC_W:0]   sum;

  // Pick the 23 fraction bits below the leading one, then round the tail.
  always_comb begin
    m        = p[45:23];
    g        = p[22];
    s        = |p[21:0];
    norm_inc = 1'b0;
    if (p[47]) begin
      m        = p[46:24];
      g        = p[23];
      s        = |p[22:0];
      norm_inc = 1'b1;
    end
    up      = g & (s | m[0]);
    sum     = {1'b0, m} + {{FRAC_W{1'b0}}, up};
    frac    = sum[FRAC_W-1:0];
    inc     = {1'b0, norm_inc} + {1'b0, sum[FRAC_W]};
    inexact = g | s;
  end

endmodule

// File: rtl/fmul_stg3_round.sv
// fmul_stg3_round: final multiplier stage. Finishes the mantissa product,
// rounds, range-checks the exponent and registers the packed result into
// stage 4 behind a valid/ready handshake.
module fmul_stg3_round
  import fpu_pkg::*;
(
  input  logic              clk,
  input  logic              nRESET,
  input  logic              valid_3,
  output logic              ready_3,
  input  logic [EXP_W-1:0]  A_exp_3,
  input  logic [EXP_W-1:0]  B_exp_3,
  input  logic [FRAC_W-1:0] A_frac_3,
  input  logic [FRAC_W-1:0] B_frac_3,
  input  logic              sign_3,
  input  logic              primal_3,
  input  logic [EXP_W-1:0]  primal_exp_3,
  input  logic [FRAC_W-1:0] primal_frac_3,
  input  logic              error_3,
  input  logic [C1_W-1:0]   c1_3,
  output logic              valid_4,
  input  logic              ready_4,
  output logic [31:0]       result_4,
  output logic              overflow_4,
  output logic              underflow_4,
  output logic              inexact_4,
  output logic              error_4
);

  logic [MANT_W-1:0]  mant_a;
  logic [MANT_W-1:0]  mant_b;
  logic [C1_W-1:0]    c2;
  logic [PROD_W-1:0]  prod;
  logic [FRAC_W-1:0]  rnd_frac;
  logic [1:0]         rnd_inc;
  logic               rnd_inexact;
  logic [EXP_X_W-1:0] exp_sum;
  logic               exp_over;
  logic               exp_under;
  logic [31:0]        next_result;
  flags_t             next_flags;
  flags_t             flags_q;
  logic               unused_low_b;

  assign mant_a = {1'b1, A_frac_3};
  assign mant_b = {1'b1, B_frac_3};

  // The low half of mant_b was already multiplied upstream into c1_3.
  assign unused_low_b = ^mant_b[11:0];

  assign c2   = {12'b0, mant_a} * {24'b0, mant_b[23:12]};
  assign prod = {12'b0, c1_3} + {c2, 12'b0};

  fmul_round_rne u_rne (
    .p       (prod),
    .frac    (rnd_frac),
    .inc     (rnd_inc),
    .inexact (rnd_inexact)
  );

  // Sum range is -127..383, so bit 9 acts as the sign bit.
  assign exp_sum   = {2'b00, A_exp_3} + {2'b00, B_exp_3} - BIAS_X
                   + {{(EXP_X_W-2){1'b0}}, rnd_inc};
  assign exp_over  = !exp_sum[EXP_X_W-1] && (exp_sum >= EXP_X_W'(255));
  assign exp_under = exp_sum[EXP_X_W-1] || (exp_sum == '0);

  assign ready_3 = !valid_4 || ready_4;

  // Choose the packed result and flags, errors and bypasses first.
  always_comb begin
    next_result = {sign_3, exp_sum[EXP_W-1:0], rnd_frac};
    next_flags  = '0;
    next_flags.inexact = rnd_inexact;
    if (error_3) begin
      next_result      = {sign_3, EXP_MAX, QNAN_FRAC};
      next_flags       = '0;
      next_flags.error = 1'b1;
    end else if (primal_3) begin
      next_result = {sign_3, primal_exp_3, primal_frac_3};
      next_flags  = '0;
    end else if (exp_over) begin
      next_result         = {sign_3, EXP_MAX, {FRAC_W{1'b0}}};
      next_flags          = '0;
      next_flags.overflow = 1'b1;
      next_flags.inexact  = 1'b1;
    end else if (exp_under) begin
      next_result          = {sign_3, 31'b0};
      next_flags           = '0;
      next_flags.underflow = 1'b1;
      next_flags.inexact   = 1'b1;
    end
  end

  // Stage-4 register: advances whenever downstream has room, bubbles included.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      valid_4  <= 1'b0;
      result_4 <= '0;
      flags_q  <= '0;
    end else if (ready_3) begin
      valid_4  <= valid_3;
      result_4 <= next_result;
      flags_q  <= next_flags;
    end
  end

  assign overflow_4  = flags_q.overflow;
  assign underflow_4 = flags_q.underflow;
  assign inexact_4   = flags_q.inexact;
  assign error_4     = flags_q.error;

endmodule

// File: tb/tb_fmul_stg3_round.sv
// tb_fmul_stg3_round: directed and random stimulus against a full-product
// arithmetic reference model and a transaction-level handshake model.
module tb_fmul_stg3_round;

  logic        clk = 1'b0;
  logic        nRESET = 1'b1;
  logic        valid_3 = 1'b0;
  logic        ready_3;
  logic [7:0]  A_exp_3 = '0;
  logic [7:0]  B_exp_3 = '0;
  logic [22:0] A_frac_3 = '0;
  logic [22:0] B_frac_3 = '0;
  logic        sign_3 = 1'b0;
  logic        primal_3 = 1'b0;
  logic [7:0]  primal_exp_3 = '0;
  logic [22:0] primal_frac_3 = '0;
  logic        error_3 = 1'b0;
  logic [35:0] c1_3 = '0;
  logic        valid_4;
  logic        ready_4 = 1'b0;
  logic [31:0] result_4;
  logic        overflow_4;
  logic        underflow_4;
  logic        inexact_4;
  logic        error_4;

  typedef struct packed {
    logic        valid;
    logic        sign;
    logic        primal;
    logic        err;
    logic [7:0]  a_exp;
    logic [7:0]  b_exp;
    logic [22:0] a_frac;
    logic [22:0] b_frac;
    logic [7:0]  p_exp;
    logic [22:0] p_frac;
  } stim_t;

  // flags ordered {overflow, underflow, inexact, error}
  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  flags;
  } out_t;

  int    checks = 0;
  int    errors = 0;
  logic  exp_valid = 1'b0;
  out_t  exp_out = '0;
  stim_t cur = '0;

  fmul_stg3_round dut (
    .clk           (clk),
    .nRESET        (nRESET),
    .valid_3       (valid_3),
    .ready_3       (ready_3),
    .A_exp_3       (A_exp_3),
    .B_exp_3       (B_exp_3),
    .A_frac_3      (A_frac_3),
    .B_frac_3      (B_frac_3),
    .sign_3        (sign_3),
    .primal_3      (primal_3),
    .primal_exp_3  (primal_exp_3),
    .primal_frac_3 (primal_frac_3),
    .error_3       (error_3),
    .c1_3          (c1_3),
    .valid_4       (valid_4),
    .ready_4       (ready_4),
    .result_4      (result_4),
    .overflow_4    (overflow_4),
    .underflow_4   (underflow_4),
    .inexact_4     (inexact_4),
    .error_4       (error_4)
  );

  // Free-running clock, 10-unit period.
  always #5 clk = ~clk;

  // Reference: exact product, round by comparing the dropped tail to one half.
  function automatic out_t ref_model(input stim_t s);
    out_t   o;
    longint prod;
    longint q;
    longint rem;
    longint half;
    int     sh;
    int     e;
    o    = '0;
    prod = longint'({1'b1, s.a_frac}) * longint'({1'b1, s.b_frac});
    sh   = (prod >= (longint'(1) << 47)) ? 24 : 23;
    q    = prod >> sh;
    rem  = prod - (q << sh);
    half = longint'(1) << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    e = int'(s.a_exp) + int'(s.b_exp) - 127 + (sh - 23);
    if (q == (longint'(1) << 24)) begin
      q = longint'(1) << 23;
      e = e + 1;
    end
    if (s.err) begin
      o.result = {s.sign, 8'hFF, 23'h400000};
      o.flags  = 4'b0001;
    end else if (s.primal) begin
      o.result = {s.sign, s.p_exp, s.p_frac};
      o.flags  = 4'b0000;
    end else if (e >= 255) begin
      o.result = {s.sign, 8'hFF, 23'h0};
      o.flags  = 4'b1010;
    end else if (e <= 0) begin
      o.result = {s.sign, 31'b0};
      o.flags  = 4'b0110;
    end else begin
      o.result = {s.sign, e[7:0], q[22:0]};
      o.flags  = {2'b00, rem != 0, 1'b0};
    end
    return o;
  endfunction

  function automatic stim_t mk(input logic v, input logic sg, input logic [7:0] ae,
                               input logic [22:0] af, input logic [7:0] be,
                               input logic [22:0] bf);
    stim_t s;
    s        = '0;
    s.valid  = v;
    s.sign   = sg;
    s.a_exp  = ae;
    s.a_frac = af;
    s.b_exp  = be;
    s.b_frac = bf;
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input stim_t s, input logic r4);
    longint lo;
    cur           = s;
    valid_3       = s.valid;
    sign_3        = s.sign;
    primal_3      = s.primal;
    error_3       = s.err;
    A_exp_3       = s.a_exp;
    B_exp_3       = s.b_exp;
    A_frac_3      = s.a_frac;
    B_frac_3      = s.b_frac;
    primal_exp_3  = s.p_exp;
    primal_frac_3 = s.p_frac;
    lo            = longint'({1'b1, s.a_frac}) * longint'(s.b_frac[11:0]);
    c1_3          = lo[35:0];
    ready_4       = r4;
  endtask

  task automatic checkReady();
    #1;
    check("ready_3", {31'b0, ready_3}, {31'b0, (!exp_valid || ready_4)});
  endtask

  task automatic checkOutput();
    check("valid_4", {31'b0, valid_4}, {31'b0, exp_valid});
    if (exp_valid) begin
      check("result_4", result_4, exp_out.result);
      check("flags_4", {28'b0, overflow_4, underflow_4, inexact_4, error_4},
            {28'b0, exp_out.flags});
    end
  endtask

  task automatic clockStep();
    @(posedge clk);
    if (!exp_valid || ready_4) begin
      exp_valid = cur.valid;
      exp_out   = ref_model(cur);
    end
    #1;
    checkOutput();
  endtask

  task automatic checkResetState(input string tag);
    check({tag, "_valid"}, {31'b0, valid_4}, 32'd0);
    check({tag, "_result"}, result_4, 32'd0);
    check({tag, "_flags"}, {28'b0, overflow_4, underflow_4, inexact_4, error_4}, 32'd0);
    check({tag, "_ready"}, {31'b0, ready_3}, 32'd1);
  endtask

  // Directed scenarios first, then random traffic with random backpressure.
  initial begin
    stim_t s;

    $display("[TB] starting");
    #1 nRESET = 1'b0;
    #1 checkResetState("reset");
    exp_valid = 1'b0;
    @(posedge clk);
    #1 nRESET = 1'b1;

    applyStimulus(mk(1'b1, 1'b0, 8'd127, 23'h400000, 8'd127, 23'h400000), 1'b1);
    checkReady();
    clockStep();
    check("mul_1p5", result_4, 32'h40100000);
    check("mul_1p5_flags", {28'b0, overflow_4, underflow_4, inexact_4, error_4}, 32'h0);

    applyStimulus(mk(1'b1, 1'b0, 8'hFE, 23'h0, 8'hFE, 23'h0), 1'b1);
    clockStep();
    check("overflow", result_4, 32'h7F800000);
    check("overflow_flags", {28'b0, overflow_4, underflow_4, inexact_4, error_4}, 32'hA);

    applyStimulus(mk(1'b1, 1'b1, 8'd1, 23'h0, 8'd1, 23'h0), 1'b1);
    clockStep();
    check("underflow", result_4, 32'h80000000);
    check("underflow_flags", {28'b0, overflow_4, underflow_4, inexact_4, error_4}, 32'h6);

    s = mk(1'b1, 1'b1, 8'd0, 23'h0, 8'd0, 23'h0);
    s.primal = 1'b1;
    s.p_exp  = 8'hFF;
    s.p_frac = 23'h0;
    applyStimulus(s, 1'b1);
    clockStep();
    check("primal", result_4, 32'hFF800000);

    s.sign = 1'b0;
    s.err  = 1'b1;
    applyStimulus(s, 1'b1);
    clockStep();
    check("error", result_4, 32'h7FC00000);
    check("error_flag", {31'b0, error_4}, 32'd1);

    applyStimulus(mk(1'b0, 1'b0, 8'd127, 23'h0, 8'd127, 23'h0), 1'b1);
    clockStep();

    applyStimulus(mk(1'b1, 1'b0, 8'd127, 23'h400000, 8'd127, 23'h400000), 1'b1);
    clockStep();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mk(1'b1, 1'b0, 8'hF0 + 8'(i), 23'(i), 8'hFE, 23'h0), 1'b0);
      checkReady();
      check("bp_ready_low", {31'b0, ready_3}, 32'd0);
      clockStep();
      check("bp_hold", result_4, 32'h40100000);
    end
    applyStimulus(mk(1'b1, 1'b1, 8'd1, 23'h0, 8'd1, 23'h0), 1'b1);
    checkReady();
    clockStep();
    check("bp_release", result_4, 32'h80000000);

    applyStimulus(mk(1'b1, 1'b0, 8'd127, 23'h000001, 8'd127, 23'h400000), 1'b1);
    clockStep();
    check("rne_tie", result_4, 32'h3FC00002);
    check("rne_tie_inexact", {31'b0, inexact_4}, 32'd1);

    applyStimulus(mk(1'b1, 1'b0, 8'd127, 23'h0, 8'd127, 23'h0), 1'b0);
    clockStep();
    check("stall_valid", {31'b0, valid_4}, 32'd1);
    nRESET = 1'b0;
    #1 checkResetState("mid_stall_reset");
    exp_valid = 1'b0;
    @(posedge clk);
    #1 nRESET = 1'b1;
    check("no_replay", {31'b0, valid_4}, 32'd0);

    for (int n = 0; n < 300; n++) begin
      s        = '0;
      s.valid  = ($urandom_range(0, 3) != 0);
      s.sign   = 1'($urandom_range(0, 1));
      s.primal = ($urandom_range(0, 15) == 0);
      s.err    = ($urandom_range(0, 15) == 0);
      s.a_exp  = 8'($urandom_range(1, 254));
      s.b_exp  = 8'($urandom_range(1, 254));
      s.a_frac = 23'($urandom);
      s.b_frac = 23'($urandom);
      s.p_exp  = 8'($urandom);
      s.p_frac = 23'($urandom);
      applyStimulus(s, ($urandom_range(0, 3) != 0));
      checkReady();
      clockStep();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fmul_stg3_round.md
# fmul_stg3_round

Stage 3 of the pipelined single-precision multiplier. It consumes the stage-2→3 register outputs: operand exponents/fractions, sign, special-case bypass, error, and the 36-bit low partial product `c1`. It completes the 24×24 mantissa product, normalizes, rounds to nearest-even, checks exponent range, and registers the packed IEEE-754 result into stage 4 behind a valid/ready handshake.

## Interface
- `BIAS`, 127, exponent bias.
- `clk` in 1 — clock.
- `nRESET` in 1 — reset, asynchronous, active-low.
- `valid_3` in 1 — stage-3 operands valid.
- `ready_3` out 1 — stage 3 can advance; drives the upstream register enable.
- `A_exp_3`, `B_exp_3` in 8 — biased exponents.
- `A_frac_3`, `B_frac_3` in 23 — fractions without the hidden bit.
- `sign_3` in 1 — result sign, already XORed upstream.
- `primal_3` in 1 — special case; the result is the primal value.
- `primal_exp_3` in 8, `primal_frac_3` in 23 — bypass result fields.
- `error_3` in 1 — invalid operation detected upstream.
- `c1_3` in 36 — {1,A_frac}×{1,B_frac}[11:0].
- `valid_4` out 1 — result valid.
- `ready_4` in 1 — downstream accepts.
- `result_4` out 32 — packed {sign, exp, frac}.
- `overflow_4`, `underflow_4`, `inexact_4`, `error_4` out 1 — status flags.

## Operation
- mA = {1,A_frac_3}, mB = {1,B_frac_3}.
- c2 = mA × mB[23:12] (36 b).
- P = c1_3 + (c2 << 12), 48 b.
- Normalize:
  - If P[47]=1: m=P[46:24], g=P[23], s=|P[22:0], inc=1.
  - Else: m=P[45:23], g=P[22], s=|P[21:0], inc=0.
- Round (RNE): up = g & (s | m[0]). m' = m + up.
  - Carry out of m' → m'=0 and inc+1.
- Exponent: e = A_exp + B_exp − BIAS + inc, computed as 10-bit signed.
- inexact = g | s.
- Result selection, highest priority first:
  1. error_3: result={sign_3,8'hFF,23'h400000}; error=1; other flags 0.
  2. primal_3: result={sign_3,primal_exp_3,primal_frac_3}; flags 0.
  3. e ≥ 255: result={sign_3,8'hFF,0}; overflow=1, inexact=1.
  4. e ≤ 0: result={sign_3,31'b0}; underflow=1, inexact=1 (denormals are flushed).
  5. Otherwise: result={sign_3,e[7:0],m'}; inexact as computed.
- Handshake:
  - ready_3 = !valid_4 | ready_4.
  - On a clock edge with ready_3=1: valid_4<=valid_3, and result/flags load the computed values.
  - When ready_3=0, all stage-4 registers hold.
  - A bubble (valid_3=0) still loads data registers. Downstream must ignore them while valid_4=0.

## Timing
- Latency 1 cycle: valid_3 & ready_3 at edge N → valid_4=1 after edge N.
- Throughput 1 result/cycle while ready_4=1.
- Reset (async, nRESET low): valid_4, result_4, and all flags = 0 immediately. ready_3 = 1 combinationally while valid_4=0.
- Reset mid-stall: the held result is discarded, with no replay.
- ready_4 low with valid_4=1: ready_3 drops in the same cycle, combinationally. The result_4 value is stable until the accepting edge.
- Simultaneous accept and new input (valid_4 & ready_4 & valid_3): the new result replaces the old on the same edge, with no bubble.
- The entire datapath, including the c2 multiply, is combinational within one cycle between the stage-3 register and the stage-4 register.

## Structure
- Shared package `fpu_pkg` holds:
  - BIAS=127, EXP_MAX=8'hFF, QNAN_FRAC=23'h400000.
  - Field widths: EXP_W=8, FRAC_W=23, C1_W=36.
- One sub-module, `fmul_round_rne`. It takes the 48-bit P and produces m', inc, and inexact. It is purely combinational and is reused by the adder pipeline's rounding stage.
- This module contains the c2 multiply, exponent/range logic, result mux, and stage-4 register with handshake.

## Test plan
- 1.5×1.5: A_exp=B_exp=127, fracs=0x400000, c1=0, valid_3=1, ready_4=1 → next cycle result_4=0x40100000 (2.25), all flags 0.
- Overflow: A_exp=B_exp=0xFE, fracs=0, c1=0 → result_4=0x7F800000, overflow_4=1, inexact_4=1.
- Underflow: A_exp=B_exp=1, fracs=0, c1=0, sign_3=1 → result_4=0x80000000, underflow_4=1.
- Primal/error: primal_3=1, primal_exp=0xFF, primal_frac=0, sign_3=1 → 0xFF800000. Then error_3=1 → 0x7FC00000 with sign_3=0, error_4=1.
- Backpressure: capture 2.25, hold ready_4=0 for 3 cycles while changing the inputs → ready_3=0, result_4 stays 0x40100000. Raise ready_4 → the next operand appears one edge later.
- RNE tie: A_frac=0x000001, B_frac=0x400000 (1.5), c1 consistent → g=1, s=0, lsb=1 → rounds up, frac=0x400002, inexact=1. Then assert nRESET low mid-stall → valid_4 and result_4 go to 0 asynchronously.
